// File: rtl/fft_bin_buffer_pkg.sv
// Shared sizing and FSM encodings for the FFT bin ping-pong buffer.
package fft_bin_buffer_pkg;
  localparam int N_BINS = 512;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 18;

  typedef enum logic [1:0] {
    CAP_WAIT_START,
    CAP_FILL,
    CAP_DROP
  } cap_state_e;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_PRIME,
    REP_STREAM,
    REP_GAP
  } rep_state_e;
endpackage

// File: rtl/fft_bin_buffer_bin_ram.sv
// Simple dual-port bin RAM: one write port, one registered read port (1-cycle read latency).
// Read-during-write to the same word returns the old contents; the buffer never relies on it.
module bin_ram #(
  parameter int AW = 10,
  parameter int DW = 36
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fft_bin_buffer.sv
// Captures 512-bin FFT frames into a ping-pong RAM and replays each complete frame as a
// gap-free burst; first bin appears 3 cycles after the last input sample when the replay side is idle.
module fft_bin_buffer
  import fft_bin_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              xk_dv,
  input  logic [ADDR_W-1:0] xk_index,
  input  logic [DATA_W-1:0] xk_re,
  input  logic [DATA_W-1:0] xk_im,
  input  logic              consumer_ready,
  output logic              fft_done,
  output logic [ADDR_W-1:0] fft_address,
  output logic              fft_read_valid,
  output logic [DATA_W-1:0] data_in_real,
  output logic [DATA_W-1:0] data_in_imag,
  output logic              frame_dropped,
  output logic [1:0]        bank_full
);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);

  cap_state_e        cap_q, cap_d;
  logic [ADDR_W-1:0] exp_q, exp_d;
  logic              wbank_q, wbank_d;
  logic              drop_q, drop_d;
  logic [1:0]        full_q, full_d;
  rep_state_e        rep_q, rep_d;
  logic              rbank_q, rbank_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              we;
  logic              set_full;
  logic              clr_full;
  logic [ADDR_W-1:0] rd_bin;
  logic [2*DATA_W-1:0] rd_dat;
  logic              streaming;

  bin_ram #(.AW(ADDR_W + 1), .DW(2 * DATA_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i ({wbank_q, xk_index}),
    .wdata_i ({xk_re, xk_im}),
    .raddr_i ({rbank_q, rd_bin}),
    .rdata_o (rd_dat)
  );

  always_comb begin
    cap_d    = cap_q;
    exp_d    = exp_q;
    wbank_d  = wbank_q;
    drop_d   = 1'b0;
    we       = 1'b0;
    set_full = 1'b0;
    unique case (cap_q)
      CAP_WAIT_START: begin
        if (xk_dv && xk_index == '0) begin
          // A full bank is never overwritten: skip the whole incoming frame.
          if (full_q[wbank_q]) begin
            drop_d = 1'b1;
            cap_d  = CAP_DROP;
          end else begin
            we    = 1'b1;
            exp_d = ADDR_W'(1);
            cap_d = CAP_FILL;
          end
        end
      end
      CAP_FILL: begin
        if (xk_dv) begin
          if (xk_index == exp_q) begin
            we = 1'b1;
            if (xk_index == LAST_BIN) begin
              set_full = 1'b1;
              wbank_d  = ~wbank_q;
              cap_d    = CAP_WAIT_START;
            end else begin
              exp_d = exp_q + 1'b1;
            end
          end else begin
            drop_d = 1'b1;
            // An out-of-order index 0 is the start of a fresh frame in the same bank.
            if (xk_index == '0) begin
              we    = 1'b1;
              exp_d = ADDR_W'(1);
            end else begin
              cap_d = CAP_WAIT_START;
            end
          end
        end
      end
      CAP_DROP: begin
        if (xk_dv && xk_index == LAST_BIN) cap_d = CAP_WAIT_START;
      end
      default: cap_d = CAP_WAIT_START;
    endcase
  end

  always_comb begin
    rep_d    = rep_q;
    rbank_d  = rbank_q;
    cnt_d    = cnt_q;
    rd_bin   = '0;
    clr_full = 1'b0;
    unique case (rep_q)
      REP_IDLE: begin
        if (full_q[rbank_q] && consumer_ready) rep_d = REP_PRIME;
      end
      REP_PRIME: begin
        cnt_d = '0;
        rep_d = REP_STREAM;
      end
      REP_STREAM: begin
        // Read one bin ahead so the RAM output lines up with fft_address.
        rd_bin = cnt_q + 1'b1;
        if (cnt_q == LAST_BIN) begin
          clr_full = 1'b1;
          rbank_d  = ~rbank_q;
          cnt_d    = '0;
          rep_d    = REP_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REP_GAP:  rep_d = REP_IDLE;
      default:  rep_d = REP_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wbank_q] = 1'b1;
    if (clr_full) full_d[rbank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q   <= CAP_WAIT_START;
      exp_q   <= '0;
      wbank_q <= 1'b0;
      drop_q  <= 1'b0;
      full_q  <= 2'b00;
      rep_q   <= REP_IDLE;
      rbank_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cap_q   <= cap_d;
      exp_q   <= exp_d;
      wbank_q <= wbank_d;
      drop_q  <= drop_d;
      full_q  <= full_d;
      rep_q   <= rep_d;
      rbank_q <= rbank_d;
      cnt_q   <= cnt_d;
    end
  end

  assign streaming      = (rep_q == REP_STREAM);
  assign fft_done       = streaming;
  assign fft_read_valid = streaming;
  assign fft_address    = streaming ? cnt_q : '0;
  assign data_in_real   = streaming ? rd_dat[2*DATA_W-1:DATA_W] : '0;
  assign data_in_imag   = streaming ? rd_dat[DATA_W-1:0] : '0;
  assign frame_dropped  = drop_q;
  assign bank_full      = full_q;
endmodule
